// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 4-slot TDM link.
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    HUNT,
    COLLECT
  } tdm_state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot tracker: load-to-1 on a new frame, step on accept, flag slot 3.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              wrap
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      slot <= '0;
    else if (load)
      slot <= SLOT_W'(1);
    else if (inc)
      slot <= slot + 1'b1;
  end

  assign wrap = (slot == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM receive demux with atomic frame publish.
// Optional err_count port under TDM_DEMUX_ERRCNT_EN.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [WIDTH-1:0]     in_data,
  output logic [4*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  output logic                 frame_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  tdm_state_t        state_q, state_d;
  logic [SLOT_W-1:0] slot;
  logic              wrap;
  logic              load, inc;
  logic              wr_en, publish, err;
  logic [WIDTH-1:0]  shadow [3];

  tdm_slot_counter u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .inc   (inc),
    .slot  (slot),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= HUNT;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    wr_en   = 1'b0;
    publish = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (in_valid && in_sof) begin
          load    = 1'b1;
          wr_en   = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (in_sof) begin
            // early sof restarts the frame from slot 0
            load  = 1'b1;
            wr_en = 1'b1;
            err   = 1'b1;
          end else begin
            inc = 1'b1;
            if (wrap) begin
              publish = 1'b1;
              state_d = HUNT;
            end else begin
              wr_en = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      shadow[0] <= '0;
      shadow[1] <= '0;
      shadow[2] <= '0;
    end else begin
      out_valid <= publish;
      frame_err <= err;
      if (wr_en) begin
        unique case (1'b1)
          load:         shadow[0] <= in_data;
          slot == 2'd1: shadow[1] <= in_data;
          default:      shadow[2] <= in_data;
        endcase
      end
      if (publish)
        out_data <= {in_data, shadow[2], shadow[1], shadow[0]};
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= '0;
    else if (err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed bench for tdm_demux_1x4 (WIDTH=8).
module tb_tdm_demux_1x4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        frame_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int total = 0;
  int bad   = 0;

  tdm_demux_1x4 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_err (frame_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    do_reset();
    check("rst_data", out_data, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_err", {31'b0, frame_err}, 32'h0);

    // 1: basic frame
    step(1, 1, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    check("t1_pre_valid", {31'b0, out_valid}, 32'h0);
    step(1, 0, 8'h44);
    check("t1_valid", {31'b0, out_valid}, 32'h1);
    check("t1_data", out_data, 32'h44332211);
    check("t1_err", {31'b0, frame_err}, 32'h0);
    step(0, 0, 8'h00);
    check("t1_valid_off", {31'b0, out_valid}, 32'h0);
    check("t1_hold", out_data, 32'h44332211);

    // 2: beats before sof are dropped
    do_reset();
    step(1, 0, 8'hAA);
    step(1, 0, 8'hBB);
    check("t2_drop_valid", {31'b0, out_valid}, 32'h0);
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 0, 8'h03);
    check("t2_pre_valid", {31'b0, out_valid}, 32'h0);
    step(1, 0, 8'h04);
    check("t2_valid", {31'b0, out_valid}, 32'h1);
    check("t2_data", out_data, 32'h04030201);
    step(0, 0, 8'h00);
    check("t2_single", {31'b0, out_valid}, 32'h0);

    // 3: 2-cycle gaps between beats
    step(1, 1, 8'h11);
    step(0, 0, 8'hEE); step(0, 0, 8'hEE);
    step(1, 0, 8'h22);
    step(0, 1, 8'hEE); step(0, 0, 8'hEE);
    step(1, 0, 8'h33);
    step(0, 0, 8'hEE);
    check("t3_gap_valid", {31'b0, out_valid}, 32'h0);
    step(0, 0, 8'hEE);
    check("t3_gap_hold", out_data, 32'h04030201);
    step(1, 0, 8'h44);
    check("t3_valid", {31'b0, out_valid}, 32'h1);
    check("t3_data", out_data, 32'h44332211);

    // 4: early sof truncates
    step(1, 1, 8'h10);
    step(1, 0, 8'h20);
    step(1, 1, 8'h55);
    check("t4_err", {31'b0, frame_err}, 32'h1);
    check("t4_err_novalid", {31'b0, out_valid}, 32'h0);
    check("t4_hold", out_data, 32'h44332211);
    step(1, 0, 8'h66);
    check("t4_err_once", {31'b0, frame_err}, 32'h0);
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    check("t4_valid", {31'b0, out_valid}, 32'h1);
    check("t4_data", out_data, 32'h88776655);
    check("t4_err_low", {31'b0, frame_err}, 32'h0);

    // 5: back-to-back frames
    step(1, 1, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    step(1, 0, 8'hA4);
    check("t5_valid_a", {31'b0, out_valid}, 32'h1);
    check("t5_data_a", out_data, 32'hA4A3A2A1);
    step(1, 1, 8'hB1);
    check("t5_b2b_err", {31'b0, frame_err}, 32'h0);
    check("t5_valid_gap", {31'b0, out_valid}, 32'h0);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hB3);
    check("t5_hold_a", out_data, 32'hA4A3A2A1);
    step(1, 0, 8'hB4);
    check("t5_valid_b", {31'b0, out_valid}, 32'h1);
    check("t5_data_b", out_data, 32'hB4B3B2B1);

    // 6: reset mid-frame
    step(1, 1, 8'hC1);
    step(1, 0, 8'hC2);
    rst_n = 1'b0;
    step(0, 0, 8'h00);
    check("t6_rst_data", out_data, 32'h0);
    check("t6_rst_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;
    step(1, 0, 8'hC3);
    step(1, 0, 8'hC4);
    check("t6_drop", {31'b0, out_valid}, 32'h0);
    step(1, 1, 8'hD1);
    step(1, 0, 8'hD2);
    step(1, 0, 8'hD3);
    step(1, 0, 8'hD4);
    check("t6_valid", {31'b0, out_valid}, 32'h1);
    check("t6_data", out_data, 32'hD4D3D2D1);

`ifdef TDM_DEMUX_ERRCNT_EN
    do_reset();
    check("ec_rst", {24'b0, err_count}, 32'h0);
    step(1, 1, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 1, 8'(i));
    check("ec_three", {24'b0, err_count}, 32'd3);
    for (int i = 0; i < 297; i++) step(1, 1, 8'(i));
    check("ec_sat", {24'b0, err_count}, 32'd255);
    do_reset();
    check("ec_clr", {24'b0, err_count}, 32'h0);
`endif

    step(0, 0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
